pong_arena: RTL and testbench

PONG_ARENA -- requirements
Module: pong_arena

---
 rtl/pong_arena.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pong_arena.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_arena.sv
// pong_arena: Pong playfield with walls, two button-driven paddles, ball physics, a scoring FSM
// and pixel colouring. Define PONG_SPEEDUP_EN to accelerate the ball after repeated paddle hits.
module pong_arena #(
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned T_WALL_B       = 71,
    parameter int unsigned B_WALL_T       = 472,
    parameter int unsigned X_PAD1_L       = 37,
    parameter int unsigned X_PAD1_R       = 40,
    parameter int unsigned X_PAD2_L       = 600,
    parameter int unsigned X_PAD2_R       = 603,
    parameter int unsigned PAD_HEIGHT     = 72,
    parameter int unsigned PAD_VEL        = 3,
    parameter int unsigned BALL_VEL       = 2,
    parameter int unsigned BALL_VEL_MAX   = 6,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned SERVE_FRAMES   = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    input  logic        start,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        graph_on,
    output logic [11:0] graph_rgb,
    output logic        pts_1,
    output logic        pts_2,
    output logic [2:0]  level
);

    localparam logic [9:0] XMax      = 10'(X_MAX);
    localparam logic [9:0] YMax      = 10'(Y_MAX);
    localparam logic [9:0] TWallT    = 10'd64;
    localparam logic [9:0] TWallB    = 10'(T_WALL_B);
    localparam logic [9:0] BWallT    = 10'(B_WALL_T);
    localparam logic [9:0] XPad1L    = 10'(X_PAD1_L);
    localparam logic [9:0] XPad1R    = 10'(X_PAD1_R);
    localparam logic [9:0] XPad2L    = 10'(X_PAD2_L);
    localparam logic [9:0] XPad2R    = 10'(X_PAD2_R);
    localparam logic [9:0] PadH      = 10'(PAD_HEIGHT);
    localparam logic [9:0] PadVel    = 10'(PAD_VEL);
    localparam logic [9:0] BallVel   = 10'(BALL_VEL);
    localparam logic [9:0] BallX0    = 10'(X_MAX / 2);
    localparam logic [9:0] BallY0    = 10'(Y_MAX / 2);
    localparam logic [9:0] PadTop0   = 10'((Y_MAX + 1) / 2 - PAD_HEIGHT / 2);
    localparam logic [9:0] PadTopMin = 10'(T_WALL_B + 1);
    localparam logic [9:0] PadTopMax = 10'(B_WALL_T - PAD_HEIGHT);
    localparam int unsigned ScW      = $clog2(SERVE_FRAMES + 1);

    localparam logic [11:0] ColWall = 12'h00F;
    localparam logic [11:0] ColPad1 = 12'h00F;
    localparam logic [11:0] ColPad2 = 12'h0F0;
    localparam logic [11:0] ColBall = 12'hF00;
    localparam logic [11:0] ColBg   = 12'h0FF;

    // Level is 3 bits wide, so at most seven speed steps above the serve speed are representable.
    if (BALL_VEL > BALL_VEL_MAX || BALL_VEL_MAX - BALL_VEL > 7 || HITS_PER_LEVEL == 0 ||
        SERVE_FRAMES == 0) begin : g_cfg_err
        $error("pong_arena: invalid speed/serve configuration");
    end

    typedef enum logic [1:0] {StIdle, StServe, StPlay, StScore} state_e;

    state_e           state_q, state_d;
    logic [ScW-1:0]   serve_cnt_q, serve_cnt_d;
    logic [9:0]       ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic             x_dir_q, x_dir_d;  // 1 = right
    logic             y_dir_q, y_dir_d;  // 1 = down
    logic [9:0]       pad1_q, pad1_d, pad2_q, pad2_d;
    logic             pts_1_q, pts_1_d, pts_2_q, pts_2_d;
    logic             match_q;

    logic             match, frame_tick, play_tick;
    logic [9:0]       speed;
    logic [9:0]       ball_r, ball_b, pad1_b, pad2_b;
    logic             hit1, hit2, miss1, miss2;

    // Edge-detect the scan position so a stalled scan still yields a single tick.
    assign match      = (y == 10'd481) && (x == 10'd0);
    assign frame_tick = match && !match_q;
    assign play_tick  = frame_tick && (state_q == StPlay);

    assign ball_r = ball_x_q + 10'd7;
    assign ball_b = ball_y_q + 10'd7;
    assign pad1_b = pad1_q + PadH - 10'd1;
    assign pad2_b = pad2_q + PadH - 10'd1;

    assign hit1  = !x_dir_q && (ball_x_q >= XPad1L) && (ball_x_q <= XPad1R) &&
                   (ball_b >= pad1_q) && (ball_y_q <= pad1_b);
    assign hit2  = x_dir_q && (ball_r >= XPad2L) && (ball_r <= XPad2R) &&
                   (ball_b >= pad2_q) && (ball_y_q <= pad2_b);
    assign miss1 = !x_dir_q && (ball_x_q <= speed);
    assign miss2 = x_dir_q && (ball_r >= XMax - speed);

    function automatic logic [9:0] pad_next(input logic [9:0] top, input logic up,
                                            input logic dn);
        logic [9:0] res;
        res = top;
        if (dn) begin
            res = (top > PadTopMax - PadVel) ? PadTopMax : top + PadVel;
        end else if (up) begin
            res = (top < PadTopMin + PadVel) ? PadTopMin : top - PadVel;
        end
        return res;
    endfunction

`ifdef PONG_SPEEDUP_EN
    localparam logic [9:0]  BallVelMax = 10'(BALL_VEL_MAX);
    localparam int unsigned HcW        = $clog2(HITS_PER_LEVEL + 1);

    logic [9:0]     speed_q, speed_d;
    logic [2:0]     level_q, level_d;
    logic [HcW-1:0] hit_cnt_q, hit_cnt_d;
    logic           hit_any;

    assign hit_any = play_tick && (hit1 || hit2);
    assign speed   = speed_q;
    assign level   = level_q;

    // Anything outside PLAY restores serve values, so SERVE is always entered at base speed.
    always_comb begin
        speed_d   = speed_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        if (state_q != StPlay) begin
            speed_d   = BallVel;
            level_d   = 3'd0;
            hit_cnt_d = '0;
        end else if (hit_any) begin
            if (hit_cnt_q == HcW'(HITS_PER_LEVEL - 1)) begin
                hit_cnt_d = '0;
                if (speed_q < BallVelMax) begin
                    speed_d = speed_q + 10'd1;
                    level_d = level_q + 3'd1;
                end
            end else begin
                hit_cnt_d = hit_cnt_q + HcW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q   <= BallVel;
            level_q   <= 3'd0;
            hit_cnt_q <= '0;
        end else begin
            speed_q   <= speed_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end
`else
    assign speed = BallVel;
    assign level = 3'd0;
`endif

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        x_dir_d     = x_dir_q;
        y_dir_d     = y_dir_q;
        pts_1_d     = 1'b0;
        pts_2_d     = 1'b0;
        pad1_d      = pad1_q;
        pad2_d      = pad2_q;
        if (frame_tick) begin
            pad1_d = pad_next(pad1_q, btn[0], btn[1]);
            pad2_d = pad_next(pad2_q, btn[2], btn[3]);
        end
        unique case (state_q)
            StIdle: begin
                ball_x_d    = BallX0;
                ball_y_d    = BallY0;
                x_dir_d     = 1'b0;
                y_dir_d     = 1'b1;
                serve_cnt_d = '0;
                if (start) state_d = StServe;
            end
            StServe: begin
                ball_x_d = BallX0;
                ball_y_d = BallY0;
                y_dir_d  = 1'b1;
                if (frame_tick) begin
                    if (serve_cnt_q == ScW'(SERVE_FRAMES - 1)) begin
                        state_d     = StPlay;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + ScW'(1);
                    end
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (miss1) begin
                        state_d = StScore;
                        pts_2_d = 1'b1;
                        x_dir_d = 1'b0;
                    end else if (miss2) begin
                        state_d = StScore;
                        pts_1_d = 1'b1;
                        x_dir_d = 1'b1;
                    end else begin
                        if (hit1) begin
                            x_dir_d = 1'b1;
                        end else if (hit2) begin
                            x_dir_d = 1'b0;
                        end
                        if (ball_y_q <= TWallB) begin
                            y_dir_d = 1'b1;
                        end else if (ball_b >= BWallT) begin
                            y_dir_d = 1'b0;
                        end
                        ball_x_d = x_dir_d ? ball_x_q + speed : ball_x_q - speed;
                        ball_y_d = y_dir_d ? ball_y_q + speed : ball_y_q - speed;
                    end
                end
            end
            StScore: begin
                ball_x_d = BallX0;
                ball_y_d = BallY0;
                y_dir_d  = 1'b1;
                state_d  = StServe;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            serve_cnt_q <= '0;
            ball_x_q    <= BallX0;
            ball_y_q    <= BallY0;
            x_dir_q     <= 1'b0;
            y_dir_q     <= 1'b1;
            pad1_q      <= PadTop0;
            pad2_q      <= PadTop0;
            pts_1_q     <= 1'b0;
            pts_2_q     <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            x_dir_q     <= x_dir_d;
            y_dir_q     <= y_dir_d;
            pad1_q      <= pad1_d;
            pad2_q      <= pad2_d;
            pts_1_q     <= pts_1_d;
            pts_2_q     <= pts_2_d;
            match_q     <= match;
        end
    end

    assign pts_1 = pts_1_q;
    assign pts_2 = pts_2_q;

    function automatic logic [7:0] ball_rom(input logic [2:0] row);
        logic [7:0] bits;
        unique case (row)
            3'd0, 3'd7: bits = 8'h3C;
            3'd1, 3'd6: bits = 8'h7E;
            default:    bits = 8'hFF;
        endcase
        return bits;
    endfunction

    logic       wall_on, pad1_on, pad2_on, ball_box, ball_on;
    logic [2:0] ball_col, ball_row;
    logic [7:0] ball_bits;
    logic [11:0] rgb;

    // Offsets inside the 8x8 box only need the low three bits of the difference.
    assign ball_col  = x[2:0] - ball_x_q[2:0];
    assign ball_row  = y[2:0] - ball_y_q[2:0];
    assign ball_bits = ball_rom(ball_row);

    assign wall_on  = ((y >= TWallT) && (y <= TWallB)) || ((y >= BWallT) && (y <= YMax));
    assign pad1_on  = (x >= XPad1L) && (x <= XPad1R) && (y >= pad1_q) && (y <= pad1_b);
    assign pad2_on  = (x >= XPad2L) && (x <= XPad2R) && (y >= pad2_q) && (y <= pad2_b);
    assign ball_box = (x >= ball_x_q) && (x <= ball_r) && (y >= ball_y_q) && (y <= ball_b);
    assign ball_on  = ball_box && ball_bits[ball_col];

    always_comb begin
        rgb = ColBg;
        if (wall_on) begin
            rgb = ColWall;
        end else if (pad1_on) begin
            rgb = ColPad1;
        end else if (pad2_on) begin
            rgb = ColPad2;
        end else if (ball_on) begin
            rgb = ColBall;
        end
    end

    assign graph_on  = wall_on || pad1_on || pad2_on || ball_on;
    assign graph_rgb = video_on ? rgb : 12'h000;

endmodule

// File: tb/tb_pong_arena.sv
// tb_pong_arena: randomized play of pong_arena checked tick by tick against a frame-level
// game model; compile with PONG_SPEEDUP_EN to check the accelerating build.
`timescale 1ns/1ps
module tb_pong_arena;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic        start;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        graph_on;
    logic [11:0] graph_rgb;
    logic        pts_1;
    logic        pts_2;
    logic [2:0]  level;

    pong_arena dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .start     (start),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .graph_on  (graph_on),
        .graph_rgb (graph_rgb),
        .pts_1     (pts_1),
        .pts_2     (pts_2),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int PhIdle  = 0;
    localparam int PhServe = 1;
    localparam int PhPlay  = 2;

    int m_ph, m_serve, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_hits, m_pts1, m_pts2;
    byte unsigned ball_rows [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_speed();
`ifdef PONG_SPEEDUP_EN
        int s;
        s = 2 + m_hits / 4;
        return (s > 6) ? 6 : s;
`else
        return 2;
`endif
    endfunction

    function automatic int step_pad(input int top, input bit up, input bit dn);
        if (dn) return (top + 3 > 400) ? 400 : top + 3;
        if (up) return (top - 3 < 72) ? 72 : top - 3;
        return top;
    endfunction

    task automatic model_reset();
        m_ph = PhIdle; m_serve = 0; m_bx = 319; m_by = 239; m_dx = -1; m_dy = 1;
        m_p1 = 204; m_p2 = 204; m_hits = 0; m_pts1 = 0; m_pts2 = 0;
    endtask

    task automatic model_serve(input int dir);
        m_ph = PhServe; m_serve = 0; m_bx = 319; m_by = 239; m_dy = 1; m_hits = 0; m_dx = dir;
    endtask

    task automatic model_play();
        int sp;
        sp = m_speed();
        if (m_dx < 0 && m_bx <= sp) begin
            m_pts2 = 1;
            model_serve(-1);
        end else if (m_dx > 0 && m_bx + 7 >= 639 - sp) begin
            m_pts1 = 1;
            model_serve(1);
        end else begin
            if (m_dx < 0 && m_bx >= 37 && m_bx <= 40 && m_by + 7 >= m_p1 && m_by <= m_p1 + 71)
            begin
                m_dx = 1; m_hits++;
            end else if (m_dx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                         m_by + 7 >= m_p2 && m_by <= m_p2 + 71) begin
                m_dx = -1; m_hits++;
            end
            if (m_by <= 71) m_dy = 1;
            else if (m_by + 7 >= 472) m_dy = -1;
            m_bx += m_dx * sp;
            m_by += m_dy * sp;
        end
    endtask

    // Ball sees the paddles as they were before this frame's paddle move.
    task automatic model_tick(input logic [3:0] b);
        int np1, np2;
        np1 = step_pad(m_p1, b[0], b[1]);
        np2 = step_pad(m_p2, b[2], b[3]);
        m_pts1 = 0; m_pts2 = 0;
        if (m_ph == PhServe) begin
            m_serve++;
            if (m_serve == 60) begin
                m_ph = PhPlay; m_serve = 0;
            end
        end else if (m_ph == PhPlay) begin
            model_play();
        end
        m_p1 = np1; m_p2 = np2;
    endtask

    function automatic int exp_colour(input int px, input int py);
        int c, r;
        byte unsigned row;
        if ((py >= 64 && py <= 71) || (py >= 472 && py <= 479)) return 'h00F;
        if (px >= 37 && px <= 40 && py >= m_p1 && py <= m_p1 + 71) return 'h00F;
        if (px >= 600 && px <= 603 && py >= m_p2 && py <= m_p2 + 71) return 'h0F0;
        c = px - m_bx; r = py - m_by;
        if (c >= 0 && c < 8 && r >= 0 && r < 8) begin
            row = ball_rows[r];
            if (row[7 - c]) return 'hF00;
        end
        return 'h0FF;
    endfunction

    task automatic check_pixel();
        int px, py, col, sel;
        bit von;
        sel = int'($urandom_range(0, 2));
        if (sel == 0) begin
            px = m_bx - 1 + int'($urandom_range(0, 9));
            py = m_by - 1 + int'($urandom_range(0, 9));
        end else if (sel == 1) begin
            px = 35 + int'($urandom_range(0, 7));
            py = m_p1 - 2 + int'($urandom_range(0, 75));
        end else begin
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
        end
        von = 1'($urandom_range(0, 1));
        x = px[9:0]; y = py[9:0]; video_on = von;
        #1;
        col = exp_colour(px, py);
        chk("graph_on", graph_on, col != 'h0FF);
        chk("graph_rgb", graph_rgb, von ? col : 0);
        x = 10'd100; y = 10'd100;
    endtask

    task automatic check_state();
        chk("ball_x", dut.ball_x_q, m_bx);
        chk("ball_y", dut.ball_y_q, m_by);
        chk("x_dir_right", dut.x_dir_q, m_dx > 0);
        chk("pad1_top", dut.pad1_q, m_p1);
        chk("pad2_top", dut.pad2_q, m_p2);
        chk("level", level, m_speed() - 2);
        check_pixel();
    endtask

    task automatic do_tick(input logic [3:0] b);
        @(negedge clk);
        btn = b; x = 10'd0; y = 10'd481;
        @(negedge clk);
        x = 10'd100; y = 10'd100;
        model_tick(b);
        chk("pts_1", pts_1, m_pts1);
        chk("pts_2", pts_2, m_pts2);
        @(negedge clk);
        chk("pts_1_one_cycle", pts_1, 0);
        chk("pts_2_one_cycle", pts_2, 0);
        @(negedge clk);
        check_state();
    endtask

    function automatic logic [3:0] pick_btn();
        logic [3:0] b;
        b = 4'($urandom);
        if ($urandom_range(0, 9) < 7) begin
            b = 4'b0000;
            if (m_p1 + 36 < m_by + 2) b[1] = 1'b1;
            else if (m_p1 + 36 > m_by + 6) b[0] = 1'b1;
            if (m_p2 + 36 < m_by + 2) b[3] = 1'b1;
            else if (m_p2 + 36 > m_by + 6) b[2] = 1'b1;
        end
        return b;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_ph = PhServe; m_serve = 0;
    endtask

    initial begin
        reset = 1'b1; btn = 4'b0000; start = 1'b0; video_on = 1'b0;
        x = 10'd100; y = 10'd100;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_pts_1", pts_1, 0);
        chk("reset_pts_2", pts_2, 0);
        check_state();

        do_tick(4'b0011);
        chk("pad1_down_wins", dut.pad1_q, 207);
        repeat (70) do_tick(4'b0010);
        chk("pad1_bottom_limit", dut.pad1_q + 71, 471);

        pulse_start();
        repeat (60) do_tick(4'b0000);
        do_tick(4'b0000);
        chk("first_move_x", dut.ball_x_q, 317);
        chk("first_move_y", dut.ball_y_q, 241);

        repeat (1000) do_tick(pick_btn());

        for (int i = 0; i < 200 && m_ph != PhPlay; i++) do_tick(pick_btn());
        @(negedge clk);
        reset = 1'b1; btn = 4'b1111; x = 10'd0; y = 10'd481;
        @(negedge clk);
        reset = 1'b0; x = 10'd100; y = 10'd100;
        model_reset();
        chk("midplay_reset_pts_1", pts_1, 0);
        chk("midplay_reset_pts_2", pts_2, 0);
        check_state();

        pulse_start();
        repeat (1000) do_tick(pick_btn());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
